metro_code_entry: RTL and testbench

Keypad-side front end for the metro gate door controller. It collects a 4-bit access code from a keypad and submits it to the door controller as a one-cycle `validate_code` strobe with a stable `access_code`. It then watches the controller's `opendoor` line to classify the attempt as granted or denied. After `MAX_FAIL` consecutive denials it locks the keypad out for `LOCK_CYCLES` cycles.

---
 rtl/metro_code_entry.sv | 147 ++++++++++++++
 tb/tb_metro_code_entry.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/metro_code_entry.sv
// Keypad front end for the metro gate: holds a 4-bit code, submits it to the door
// controller, classifies the response as granted/denied and locks out after repeated denials.
module metro_code_entry #(
  parameter int unsigned MAX_FAIL     = 3,
  parameter int unsigned LOCK_CYCLES  = 16,
  parameter int unsigned RESP_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       door_open,
  output logic       validate_code,
  output logic [3:0] access_code,
  output logic       busy,
  output logic       granted,
  output logic       denied,
  output logic       locked,
  output logic [2:0] fail_count
);

  localparam int unsigned RESP_W = $clog2(RESP_TIMEOUT);
  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [RESP_W-1:0] RESP_LAST  = RESP_W'(RESP_TIMEOUT - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [2:0]        FAIL_LIMIT = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RESP,
    S_DOOR_OPEN,
    S_LOCKOUT
  } state_t;

  state_t            r_state,    w_state_nx;
  logic [3:0]        r_code,     w_code_nx;
  logic              r_loaded,   w_loaded_nx;
  logic [RESP_W-1:0] r_resp_cnt, w_resp_nx;
  logic [LOCK_W-1:0] r_lock_cnt, w_lock_nx;
  logic [2:0]        r_fail,     w_fail_nx;
  logic              r_granted,  w_granted_nx;
  logic              r_denied,   w_denied_nx;
  logic [2:0]        w_fail_inc;

  assign w_fail_inc = r_fail + 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_code     <= '0;
      r_loaded   <= 1'b0;
      r_resp_cnt <= '0;
      r_lock_cnt <= '0;
      r_fail     <= '0;
      r_granted  <= 1'b0;
      r_denied   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_code     <= w_code_nx;
      r_loaded   <= w_loaded_nx;
      r_resp_cnt <= w_resp_nx;
      r_lock_cnt <= w_lock_nx;
      r_fail     <= w_fail_nx;
      r_granted  <= w_granted_nx;
      r_denied   <= w_denied_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_code_nx    = r_code;
    w_loaded_nx  = r_loaded;
    w_resp_nx    = r_resp_cnt;
    w_lock_nx    = r_lock_cnt;
    w_fail_nx    = r_fail;
    w_granted_nx = 1'b0;
    w_denied_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (key_clear) begin
          w_code_nx   = '0;
          w_loaded_nx = 1'b0;
        end else if (key_enter && r_loaded) begin
          w_state_nx = S_SEND;
        end else if (key_valid) begin
          w_code_nx   = key_code;
          w_loaded_nx = 1'b1;
        end
      end
      S_SEND: begin
        w_state_nx = S_WAIT_RESP;
        w_resp_nx  = '0;
      end
      S_WAIT_RESP: begin
        if (door_open) begin
          w_granted_nx = 1'b1;
          w_fail_nx    = '0;
          w_state_nx   = S_DOOR_OPEN;
        end else if (r_resp_cnt == RESP_LAST) begin
          w_denied_nx = 1'b1;
          w_fail_nx   = w_fail_inc;
          if (w_fail_inc == FAIL_LIMIT) begin
            // code stays on access_code through lockout; it is dropped on the way back to IDLE
            w_state_nx = S_LOCKOUT;
            w_lock_nx  = '0;
          end else begin
            w_state_nx  = S_IDLE;
            w_code_nx   = '0;
            w_loaded_nx = 1'b0;
          end
        end else begin
          w_resp_nx = r_resp_cnt + 1'b1;
        end
      end
      S_DOOR_OPEN: begin
        if (!door_open) begin
          w_state_nx  = S_IDLE;
          w_code_nx   = '0;
          w_loaded_nx = 1'b0;
        end
      end
      S_LOCKOUT: begin
        if (r_lock_cnt == LOCK_LAST) begin
          w_state_nx  = S_IDLE;
          w_fail_nx   = '0;
          w_code_nx   = '0;
          w_loaded_nx = 1'b0;
        end else begin
          w_lock_nx = r_lock_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign validate_code = (r_state == S_SEND);
  assign busy          = (r_state != S_IDLE);
  assign locked        = (r_state == S_LOCKOUT);
  assign access_code   = r_code;
  assign granted       = r_granted;
  assign denied        = r_denied;
  assign fail_count    = r_fail;

endmodule

// File: tb/tb_metro_code_entry.sv
// Bench for metro_code_entry: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against an attempt-age model.
module tb_metro_code_entry;

  localparam int MAXF  = 3;
  localparam int LOCKC = 16;
  localparam int RTO   = 4;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       key_valid = 1'b0, key_enter = 1'b0, key_clear = 1'b0, door_open = 1'b0;
  logic [3:0] key_code = '0;
  logic       validate_code, busy, granted, denied, locked;
  logic [3:0] access_code;
  logic [2:0] fail_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  metro_code_entry #(.MAX_FAIL(MAXF), .LOCK_CYCLES(LOCKC), .RESP_TIMEOUT(RTO)) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
    .key_enter(key_enter), .key_clear(key_clear), .door_open(door_open),
    .validate_code(validate_code), .access_code(access_code), .busy(busy),
    .granted(granted), .denied(denied), .locked(locked), .fail_count(fail_count)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: one attempt spans the submit cycle (age 0) and RTO response cycles (ages 1..RTO).
  localparam int M_IDLE = 0, M_TRY = 1, M_OPEN = 2, M_LOCK = 3;
  int m_mode = M_IDLE, m_age = 0, m_code = 0, m_fail = 0;
  bit m_loaded = 1'b0, m_gnt = 1'b0, m_den = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= M_IDLE; m_age <= 0; m_code <= 0; m_fail <= 0;
      m_loaded <= 1'b0; m_gnt <= 1'b0; m_den <= 1'b0;
    end else begin
      m_gnt <= 1'b0;
      m_den <= 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (key_clear) begin m_code <= 0; m_loaded <= 1'b0; end
          else if (key_enter && m_loaded) begin m_mode <= M_TRY; m_age <= 0; end
          else if (key_valid) begin m_code <= int'(key_code); m_loaded <= 1'b1; end
        end
        M_TRY: begin
          if (m_age > 0 && door_open) begin
            m_gnt <= 1'b1; m_fail <= 0; m_mode <= M_OPEN;
          end else if (m_age == RTO) begin
            m_den  <= 1'b1;
            m_fail <= m_fail + 1;
            if (m_fail + 1 == MAXF) begin m_mode <= M_LOCK; m_age <= 0; end
            else begin m_mode <= M_IDLE; m_code <= 0; m_loaded <= 1'b0; end
          end else m_age <= m_age + 1;
        end
        M_OPEN: if (!door_open) begin m_mode <= M_IDLE; m_code <= 0; m_loaded <= 1'b0; end
        default: begin
          if (m_age == LOCKC - 1) begin
            m_mode <= M_IDLE; m_fail <= 0; m_code <= 0; m_loaded <= 1'b0;
          end else m_age <= m_age + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("validate_code", int'(validate_code), int'(m_mode == M_TRY && m_age == 0));
    chk("busy",          int'(busy),          int'(m_mode != M_IDLE));
    chk("locked",        int'(locked),        int'(m_mode == M_LOCK));
    chk("granted",       int'(granted),       int'(m_gnt));
    chk("denied",        int'(denied),        int'(m_den));
    chk("access_code",   int'(access_code),   m_code);
    chk("fail_count",    int'(fail_count),    m_fail);
  end

  task automatic submit(input logic [3:0] code);
    @(negedge clk); key_valid = 1'b1; key_code = code;
    @(negedge clk); key_valid = 1'b0; key_enter = 1'b1;
  endtask

  task automatic deny_run(input logic [3:0] code, input int exp_fail);
    submit(code);
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      key_enter = 1'b0;
      if (t == 5) chk("deny_not_yet", int'(denied), 0);
      if (t == 6) begin
        chk("deny_pulse", int'(denied), 1);
        chk("deny_fail_count", int'(fail_count), exp_fail);
      end
    end
  endtask

  int unsigned r;
  int door_wait = 0, door_left = 0, door_len = 0;
  bit stray;

  initial begin
    // reset state
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_access_code", int'(access_code), 0);
    chk("reset_fail_count", int'(fail_count), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // deny path, then a key accepted in the very first IDLE cycle
    deny_run(4'd2, 1);
    chk("deny_idle", int'(busy), 0);
    chk("deny_code_cleared", int'(access_code), 0);
    key_valid = 1'b1; key_code = 4'd9;
    @(negedge clk);
    key_valid = 1'b0;
    chk("reentry_first_idle", int'(access_code), 9);

    // grant path with an 8-cycle door; fail_count goes from 1 to 0
    submit(4'd7);
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      key_enter = 1'b0;
      door_open = (t >= 3 && t <= 10);
      if (t == 1) chk("grant_validate_n1", int'(validate_code), 1);
      if (t == 2) chk("grant_validate_n2", int'(validate_code), 0);
      if (t <= 11) chk("grant_access_code", int'(access_code), 7);
      if (t == 3) chk("grant_fail_before", int'(fail_count), 1);
      if (t == 3) chk("grant_not_early", int'(granted), 0);
      if (t == 4) chk("grant_pulse", int'(granted), 1);
      if (t == 4) chk("grant_fail_after", int'(fail_count), 0);
      if (t == 5) chk("grant_single", int'(granted), 0);
      if (t == 11) chk("grant_busy_n11", int'(busy), 1);
      if (t == 12) chk("grant_busy_n12", int'(busy), 0);
      if (t == 12) chk("grant_code_cleared", int'(access_code), 0);
    end

    // priority: clear beats enter and valid; enter with nothing loaded is ignored
    @(negedge clk); key_valid = 1'b1; key_code = 4'd3;
    @(negedge clk); key_clear = 1'b1; key_enter = 1'b1; key_code = 4'd5;
    @(negedge clk); key_clear = 1'b0; key_enter = 1'b0; key_valid = 1'b0;
    chk("prio_no_submit", int'(validate_code), 0);
    chk("prio_code_cleared", int'(access_code), 0);
    key_enter = 1'b1;
    @(negedge clk); key_enter = 1'b0;
    chk("enter_unloaded", int'(validate_code), 0);
    @(negedge clk);
    chk("enter_unloaded_idle", int'(busy), 0);

    // lockout after three consecutive denials
    deny_run(4'd15, 1);
    deny_run(4'd15, 2);
    submit(4'd15);
    for (int t = 1; t <= 23; t++) begin
      @(negedge clk);
      key_enter = 1'b0; key_valid = 1'b0;
      if (t >= 7 && t <= 21) begin
        key_valid = (t % 2 == 0); key_enter = (t % 2 == 1); key_code = 4'd9;
      end
      if (t == 5) chk("lock_not_yet", int'(locked), 0);
      if (t == 6) chk("lock_denied", int'(denied), 1);
      if (t == 6) chk("lock_fail_count", int'(fail_count), 3);
      if (t >= 6 && t <= 21) chk("lock_held", int'(locked), 1);
      if (t >= 7) chk("lock_keys_ignored", int'(validate_code), 0);
      if (t == 22) chk("lock_released", int'(locked), 0);
      if (t == 22) chk("lock_fail_reset", int'(fail_count), 0);
      if (t == 23) chk("lock_idle", int'(busy), 0);
    end

    // reset during WAIT_RESP, then a normal submit of code 4
    submit(4'd6);
    for (int t = 1; t <= 3; t++) begin @(negedge clk); key_enter = 1'b0; end
    reset_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_code", int'(access_code), 0);
    chk("rst_denied", int'(denied), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    submit(4'd4);
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      key_enter = 1'b0;
      if (t == 1) chk("post_rst_validate", int'(validate_code), 1);
      if (t == 1) chk("post_rst_code", int'(access_code), 4);
      if (t == 6) chk("post_rst_deny", int'(denied), 1);
    end

    // randomized run: one key strobe at most per cycle, random door responder and strays
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      key_valid = (r < 15);
      key_enter = (r >= 15 && r < 30);
      key_clear = (r >= 30 && r < 34);
      key_code  = 4'($urandom);
      reset_n   = ($urandom_range(0, 999) >= 3);
      stray     = ($urandom_range(0, 99) < 3);
      if (door_wait > 0) begin
        door_wait--;
        if (door_wait == 0) door_left = door_len;
      end
      if (door_left > 0) begin door_open = 1'b1; door_left--; end
      else door_open = stray;
      if (validate_code && door_wait == 0 && door_left == 0 && $urandom_range(0, 9) < 6) begin
        door_wait = int'($urandom_range(1, 6));
        door_len  = int'($urandom_range(1, 10));
      end
    end

    @(negedge clk);
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; door_open = 1'b0; reset_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
